ctrl_multiciclo: RTL
====================

// Module: ctrl_multiciclo
// PURPOSE
//  Multicycle main control FSM for the CPU datapath. Sequences fetch, decode, execute, memory and writeback.
//  Drives the shared ALU selector (alu_sel) and all datapath write enables and mux selects.
//  Handles a fixed-latency memory wait, branch resolution from ALU flags, exceptions and BREAK halt.
// PARAMETERS
//  MEM_LAT  2  memory wait cycles before read data is valid (1..15); also the hold time for writes
// PORTS
//  clock         in   1  system clock; all state changes on its rising edge
//  reset         in   1  synchronous, active-high reset
//  opcode        in   6  IR[31:26], stable from the end of FETCH until the next FETCH
//  funct         in   6  IR[5:0]
//  alu_zero      in   1  ALU result == 0
//  alu_overflow  in   1  signed overflow of the current ALU operation
//  pc_write      out  1  PC load enable
//  pc_src        out  2  PC input: 00 ALU result, 01 ALUOut (branch target), 10 reg A (jr), 11 exception vector
//  ir_write      out  1  IR load enable
//  mem_rd        out  1  memory read strobe
//  mem_wr        out  1  memory write strobe
//  addr_src      out  1  memory address: 0 PC, 1 ALUOut
//  alu_src_a     out  1  ALU A operand: 0 PC, 1 reg A
//  alu_src_b     out  2  ALU B operand: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_sel       out  3  001 add, 010 sub, 011 and, 000 pass A
//  reg_write     out  1  register-file write enable
//  reg_dst       out  1  write register: 0 rt, 1 rd
//  mem_to_reg    out  1  writeback data: 0 ALUOut, 1 MDR
//  epc_write     out  1  EPC load enable
//  exc_cause     out  1  registered cause: 0 invalid opcode, 1 overflow
//  state_out     out  4  current state encoding (debug)
// BEHAVIOUR
//  - reset=1 at a clock edge: state <= RST (0) from any state, including mid memory wait. Wait counter <= 0, exc_cause <= 0.
//    In RST every output is 0. RST always moves to FETCH on the next cycle.
//  - Moore outputs are decoded from state. Exception: pc_write in BRANCH depends on alu_zero.
//    Any output not listed for a state is 0.
//  - States (encoding): RST 0, FETCH 1, DECODE 2, EXEC_R 3, WB_R 4, EXEC_I 5, WB_I 6, MEM_ADDR 7,
//    MEM_RD 8, MEM_WB 9, MEM_WR 10, BRANCH 11, JR 12, EXC 13, HALT 14.
//  - FETCH: mem_rd=1, addr_src=0. Stays MEM_LAT+1 cycles, counted by the wait counter.
//    On the last cycle: ir_write=1, pc_write=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_sel=001 (PC+4). Counter <= 0.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_sel=001 (branch target -> ALUOut). Next state:
//    opcode 0 with funct 20/22/24 -> EXEC_R; funct 08 -> JR; funct 0D -> HALT
//    opcode 08/09 -> EXEC_I; opcode 23/2B -> MEM_ADDR; opcode 04/05 -> BRANCH
//    any other opcode/funct -> EXC with exc_cause <= 0
//  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_sel = 001/010/011 for funct 20/22/24. Next WB_R.
//  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
//  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_sel=001. Next WB_I.
//  - WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
//  - MEM_ADDR: EXEC_I operand selects, computes A+imm. Next MEM_RD (lw) or MEM_WR (sw).
//  - MEM_RD: mem_rd=1, addr_src=1 for MEM_LAT+1 cycles. Next MEM_WB.
//  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
//  - MEM_WR: mem_wr=1, addr_src=1 for MEM_LAT+1 cycles. Next FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_sel=010, pc_src=01.
//    pc_write = alu_zero for beq (04), ~alu_zero for bne (05). Next FETCH.
//  - JR: pc_write=1, pc_src=10. Next FETCH.
//  - EXC: epc_write=1, pc_write=1, pc_src=11. Next FETCH.
//  - HALT: all enables 0. Stays in HALT until reset.
//  - Wait counter is 4 bits and saturates at MEM_LAT; it never wraps.
// CONFIGURATION
//  OVERFLOW_EXC_EN defined:
//    - in EXEC_R (add/sub) and EXEC_I (addi only, not addiu), alu_overflow=1 at the end of the cycle
//      -> next state EXC, exc_cause <= 1; the writeback state is skipped, so there is no reg_write.
//  OVERFLOW_EXC_EN undefined:
//    - alu_overflow is ignored; writeback always happens; exc_cause is only ever 0.
// TESTING
//  1. reset=1 for 2 cycles, then release -> state_out 0 then 1; all outputs 0 during reset.
//  2. MEM_LAT=2, add (op 00, funct 20) -> FETCH 3 cycles, ir_write on the 3rd cycle, then 2,3,4,1;
//     reg_write=1 only in state 4; 6 cycles total.
//  3. beq with alu_zero=1 -> pc_write=1, pc_src=01 in BRANCH; same with alu_zero=0 -> pc_write=0.
//  4. lw (op 23) -> states 1,2,7,8(x3),9; mem_to_reg=1 and reg_write=1 in state 9.
//     sw (op 2B) -> mem_wr=1 for exactly 3 cycles.
//  5. opcode 3F -> EXC with epc_write=1, pc_src=11, exc_cause=0.
//     With OVERFLOW_EXC_EN: addi with alu_overflow=1 -> EXC, exc_cause=1, no reg_write.
//  6. break (funct 0D) -> HALT held 20 cycles; reset asserted during an MEM_RD wait -> RST next cycle, mem_rd=0.

Source files
------------

// File: rtl/ctrl_multiciclo.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback with fixed-latency memory waits.
// Optional feature: define OVERFLOW_EXC_EN to trap signed overflow of add/sub/addi into EXC.
module ctrl_multiciclo #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       addr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_sel,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       epc_write,
  output logic       exc_cause,
  output logic [3:0] state_out
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JR       = 4'd12,
    S_EXC      = 4'd13,
    S_HALT     = 4'd14
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       epc_write;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exc_q, exc_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             wait_done_c;
  logic             br_take_c;

  // Control word for a given state; 'last' marks the final cycle of a memory wait.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic last, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_rd = 1'b1;
        if (last) begin
          c.ir_write  = 1'b1;
          c.pc_write  = 1'b1;
          c.pc_src    = 2'b00;
          c.alu_src_b = 2'b01;
          c.alu_sel   = ALU_ADD;
        end
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_sel   = ALU_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        case (f)
          FN_ADD:  c.alu_sel = ALU_ADD;
          FN_SUB:  c.alu_sel = ALU_SUB;
          FN_AND:  c.alu_sel = ALU_AND;
          default: c.alu_sel = ALU_PASS;
        endcase
      end
      S_WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_sel   = ALU_ADD;
      end
      S_WB_I: c.reg_write = 1'b1;
      S_MEM_RD: begin
        c.mem_rd   = 1'b1;
        c.addr_src = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_wr   = 1'b1;
        c.addr_src = 1'b1;
      end
      // pc_write for branches is resolved from alu_zero in the same cycle, see br_take_c
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_sel   = ALU_SUB;
        c.pc_src    = 2'b01;
      end
      S_JR: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
      S_EXC: begin
        c.epc_write = 1'b1;
        c.pc_write  = 1'b1;
        c.pc_src    = 2'b11;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign wait_done_c = (cnt_q >= LAT);

  // Next-state, wait counter and exception cause
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (wait_done_c) begin
          cnt_d = '0;
          case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_MEM_RD: state_d = S_MEM_WB;
            default:  state_d = S_FETCH;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND: state_d = S_EXEC_R;
              FN_JR:                  state_d = S_JR;
              FN_BREAK:               state_d = S_HALT;
              default: begin
                state_d = S_EXC;
                exc_d   = 1'b0;
              end
            endcase
          end
          OP_ADDI, OP_ADDIU: state_d = S_EXEC_I;
          OP_LW, OP_SW:      state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:    state_d = S_BRANCH;
          default: begin
            state_d = S_EXC;
            exc_d   = 1'b0;
          end
        endcase
      end
      S_EXEC_R: begin
        state_d = S_WB_R;
`ifdef OVERFLOW_EXC_EN
        if (alu_overflow && (funct == FN_ADD || funct == FN_SUB)) begin
          state_d = S_EXC;
          exc_d   = 1'b1;
        end
`endif
      end
      S_EXEC_I: begin
        state_d = S_WB_I;
`ifdef OVERFLOW_EXC_EN
        if (alu_overflow && opcode == OP_ADDI) begin
          state_d = S_EXC;
          exc_d   = 1'b1;
        end
`endif
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JR, S_EXC: state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_RST;
        cnt_d   = '0;
      end
    endcase
    ctrl_d = decode_ctrl(state_d, (cnt_d == LAT), funct);
  end

`ifndef OVERFLOW_EXC_EN
  logic ovf_unused;
  assign ovf_unused = alu_overflow;
`endif

  // State, counter, cause and the control word for the upcoming state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign br_take_c = (state_q == S_BRANCH) &&
                     ((opcode == OP_BNE) ? !alu_zero : alu_zero);

  assign pc_write   = ctrl_q.pc_write | br_take_c;
  assign pc_src     = ctrl_q.pc_src;
  assign ir_write   = ctrl_q.ir_write;
  assign mem_rd     = ctrl_q.mem_rd;
  assign mem_wr     = ctrl_q.mem_wr;
  assign addr_src   = ctrl_q.addr_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_sel    = ctrl_q.alu_sel;
  assign reg_write  = ctrl_q.reg_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign epc_write  = ctrl_q.epc_write;
  assign exc_cause  = exc_q;
  assign state_out  = state_q;

endmodule
